// File: rtl/minmax_job_sequencer.sv
// Two-requester round-robin job sequencer driving the min/max accelerator MMIO bus.
// Define MINMAX_SEQ_POLL_TIMEOUT_EN to bound trigger polling to POLL_LIMIT reads (res_err).
module minmax_job_sequencer #(
    parameter logic [31:0] ACC_BASE   = 32'hC200_0000,
    parameter int unsigned POLL_LIMIT = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [255:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [255:0] req1_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [31:0]  res_min,
    output logic [31:0]  res_max,
    output logic         res_err,
    output logic         acc_en,
    output logic         acc_wr,
    output logic [31:0]  acc_waddr,
    output logic [31:0]  acc_raddr,
    output logic [31:0]  acc_din,
    input  logic [31:0]  acc_dout,
    input  logic         acc_rready,
    input  logic         acc_wready
);

    localparam logic [31:0] MinAddr  = ACC_BASE + 32'h20;
    localparam logic [31:0] MaxAddr  = ACC_BASE + 32'h24;
    localparam logic [31:0] TrigAddr = ACC_BASE + 32'h28;

    typedef enum logic [3:0] {
        StIdle, StWrA, StWrAW, StWrT, StWrTW, StPoll, StPollW,
        StRdMin, StRdMinW, StRdMax, StRdMaxW, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [255:0]  buf_q, buf_d;
    logic [2:0]    idx_q, idx_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic [31:0]   min_q, min_d;
    logic [31:0]   max_q, max_d;
    logic          grant_any;
    logic          grant_id;
    logic          poll_expired;

    assign grant_any = req0_valid | req1_valid;
    // On a tie the requester not granted last wins.
    assign grant_id  = (req0_valid & req1_valid) ? ~last_q : req1_valid;

`ifdef MINMAX_SEQ_POLL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(POLL_LIMIT + 1);

    logic [CntW-1:0] poll_cnt_q, poll_cnt_d;
    logic            err_q, err_d;

    assign poll_expired = (poll_cnt_q >= CntW'(POLL_LIMIT));

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        err_d      = err_q;
        if (state_q == StWrT) begin
            poll_cnt_d = '0;
        end else if (state_q == StPoll) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end
        if (state_q == StIdle && grant_any) begin
            err_d = 1'b0;
        end else if (state_q == StPollW && acc_rready && acc_dout != '0 && poll_expired) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
        end
    end

    assign res_err = err_q;
`else
    assign poll_expired = 1'b0;
    assign res_err      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        last_d  = last_q;
        id_d    = id_q;
        min_d   = min_q;
        max_d   = max_q;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    state_d = StWrA;
                    buf_d   = grant_id ? req1_data : req0_data;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    idx_d   = '0;
                end
            end
            StWrA:  state_d = StWrAW;
            StWrAW: begin
                if (acc_wready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StWrT;
                    end else begin
                        state_d = StWrA;
                    end
                end
            end
            StWrT:  state_d = StWrTW;
            StWrTW: if (acc_wready) state_d = StPoll;
            StPoll: state_d = StPollW;
            StPollW: begin
                if (acc_rready) begin
                    if (acc_dout == '0) begin
                        state_d = StRdMin;
                    end else if (poll_expired) begin
                        state_d = StDone;
                        min_d   = '0;
                        max_d   = '0;
                    end else begin
                        state_d = StPoll;
                    end
                end
            end
            StRdMin: state_d = StRdMinW;
            StRdMinW: begin
                if (acc_rready) begin
                    min_d   = acc_dout;
                    state_d = StRdMax;
                end
            end
            StRdMax: state_d = StRdMaxW;
            StRdMaxW: begin
                if (acc_rready) begin
                    max_d   = acc_dout;
                    state_d = StDone;
                end
            end
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus strobes are driven only in issue states, so acc_en can never appear in a wait state.
    always_comb begin
        acc_en    = 1'b0;
        acc_wr    = 1'b0;
        acc_waddr = '0;
        acc_raddr = '0;
        acc_din   = '0;
        case (state_q)
            StWrA: begin
                acc_en    = 1'b1;
                acc_wr    = 1'b1;
                acc_waddr = ACC_BASE + {27'd0, idx_q, 2'b00};
                acc_din   = buf_q[{idx_q, 5'd0} +: 32];
            end
            StWrT: begin
                acc_en    = 1'b1;
                acc_wr    = 1'b1;
                acc_waddr = TrigAddr;
                acc_din   = 32'h1;
            end
            StPoll: begin
                acc_en    = 1'b1;
                acc_raddr = TrigAddr;
            end
            StRdMin: begin
                acc_en    = 1'b1;
                acc_raddr = MinAddr;
            end
            StRdMax: begin
                acc_en    = 1'b1;
                acc_raddr = MaxAddr;
            end
            default: ;
        endcase
    end

    assign req0_ready = (state_q == StIdle) & grant_any & ~grant_id;
    assign req1_ready = (state_q == StIdle) & grant_any & grant_id;
    assign res_valid  = (state_q == StDone);
    assign res_id     = id_q;
    assign res_min    = min_q;
    assign res_max    = max_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            buf_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            id_q    <= id_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

endmodule

// File: tb/tb_minmax_job_sequencer.sv
// Directed bench for minmax_job_sequencer with a behavioural min/max accelerator on the bus.
module tb_minmax_job_sequencer;

    localparam logic [31:0] BASE = 32'hC200_0000;
    localparam logic [31:0] MINA = BASE + 32'h20;
    localparam logic [31:0] MAXA = BASE + 32'h24;
    localparam logic [31:0] TRIG = BASE + 32'h28;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [255:0] req0_data = '0, req1_data = '0;
    logic         res_valid, res_id, res_err;
    logic         res_ready = 1'b0;
    logic [31:0]  res_min, res_max;
    logic         acc_en, acc_wr;
    logic [31:0]  acc_waddr, acc_raddr, acc_din;
    logic [31:0]  acc_dout = '0;
    logic         acc_rready = 1'b0, acc_wready = 1'b0;

    always #5 clk = ~clk;

    minmax_job_sequencer #(
        .ACC_BASE   (BASE),
        .POLL_LIMIT (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_err    (res_err),
        .acc_en     (acc_en),
        .acc_wr     (acc_wr),
        .acc_waddr  (acc_waddr),
        .acc_raddr  (acc_raddr),
        .acc_din    (acc_din),
        .acc_dout   (acc_dout),
        .acc_rready (acc_rready),
        .acc_wready (acc_wready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accelerator model: trig stays set for compute_polls reads after being written.
    logic signed [31:0] mem_a [8];
    logic trig = 1'b0;
    int   trig_reads = 0;
    int   compute_polls = 2;
    bit   never_clear = 1'b0;

    function automatic logic [31:0] model_min();
        logic signed [31:0] m = mem_a[0];
        for (int k = 1; k < 8; k++) if (mem_a[k] < m) m = mem_a[k];
        return m;
    endfunction

    function automatic logic [31:0] model_max();
        logic signed [31:0] m = mem_a[0];
        for (int k = 1; k < 8; k++) if (mem_a[k] > m) m = mem_a[k];
        return m;
    endfunction

    always @(posedge clk) begin
        acc_wready <= 1'b0;
        acc_rready <= 1'b0;
        if (acc_en && acc_wr) begin
            acc_wready <= 1'b1;
            if (acc_waddr == TRIG) begin
                trig       <= acc_din[0];
                trig_reads <= 0;
            end else if (acc_waddr >= BASE && acc_waddr < BASE + 32'h20) begin
                mem_a[acc_waddr[4:2]] <= acc_din;
            end
        end else if (acc_en) begin
            acc_rready <= 1'b1;
            if (acc_raddr == TRIG) begin
                acc_dout <= {31'd0, trig};
                if (trig) begin
                    trig_reads <= trig_reads + 1;
                    if (trig_reads + 1 >= compute_polls && !never_clear) trig <= 1'b0;
                end
            end else if (acc_raddr == MINA) begin
                acc_dout <= model_min();
            end else if (acc_raddr == MAXA) begin
                acc_dout <= model_max();
            end else begin
                acc_dout <= 32'hDEAD_BEEF;
            end
        end
    end

    // Bus monitor: logs every op and counts protocol violations.
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] din;
        int          cyc;
    } op_t;

    op_t bus_log[$];
    int  bus_viol = 0;
    bit  outstanding = 1'b0;
    bit  prev_en = 1'b0;

    always @(negedge clk) begin
        if (!rst_ni) begin
            outstanding = 1'b0;
            prev_en     = 1'b0;
        end else begin
            if (acc_wready || acc_rready) outstanding = 1'b0;
            if (acc_en) begin
                if (outstanding || prev_en) bus_viol++;
                outstanding = 1'b1;
                bus_log.push_back('{acc_wr, acc_wr ? acc_waddr : acc_raddr, acc_din, cyc});
            end
            prev_en = acc_en;
        end
    end

    function automatic logic [255:0] pack8(input int w0, w1, w2, w3, w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic check_zero(input string name);
        check({name, ".res_valid"}, res_valid, 0);
        check({name, ".res_id"}, res_id, 0);
        check({name, ".res_min"}, res_min, 0);
        check({name, ".res_max"}, res_max, 0);
        check({name, ".res_err"}, res_err, 0);
        check({name, ".acc_en"}, acc_en, 0);
        check({name, ".acc_wr"}, acc_wr, 0);
        check({name, ".acc_waddr"}, acc_waddr, 0);
        check({name, ".acc_raddr"}, acc_raddr, 0);
        check({name, ".acc_din"}, acc_din, 0);
        check({name, ".req_ready"}, {req1_ready, req0_ready}, 0);
    endtask

    task automatic start_job(input string name, input bit id, input logic [255:0] data,
                             output int t_acc);
        bit seen = 1'b0;
        t_acc = 0;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1;
            req1_data  = data;
        end else begin
            req0_valid = 1'b1;
            req0_data  = data;
        end
        for (int i = 0; i < 300 && !seen; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                seen  = 1'b1;
                t_acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check({name, ".accepted"}, seen, 1);
        @(negedge clk);
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input bit eid, input logic [31:0] emin,
                               input logic [31:0] emax, input bit eerr);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (res_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, ".res_valid"}, seen, 1);
        check({name, ".res_id"}, res_id, eid);
        check({name, ".res_min"}, res_min, emin);
        check({name, ".res_max"}, res_max, emax);
        check({name, ".res_err"}, res_err, eerr);
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, ".valid_drop"}, res_valid, 0);
    endtask

    task automatic check_bus_log(input string name, input logic [255:0] data, input int polls,
                                 input int t_acc);
        int          n;
        logic [31:0] ea;
        bit          ew;
        n = 11 + polls;
        check({name, ".nops"}, bus_log.size(), n);
        if (bus_log.size() == n) begin
            for (int k = 0; k < n; k++) begin
                if (k < 8) begin
                    ew = 1'b1;
                    ea = BASE + 32'(4 * k);
                end else if (k == 8) begin
                    ew = 1'b1;
                    ea = TRIG;
                end else if (k < 9 + polls) begin
                    ew = 1'b0;
                    ea = TRIG;
                end else if (k == 9 + polls) begin
                    ew = 1'b0;
                    ea = MINA;
                end else begin
                    ew = 1'b0;
                    ea = MAXA;
                end
                check($sformatf("%s.op%0d.addr", name, k), bus_log[k].addr, ea);
                check($sformatf("%s.op%0d.wr", name, k), bus_log[k].wr, ew);
                if (k < 8) check($sformatf("%s.op%0d.din", name, k), bus_log[k].din,
                                 data[32*k +: 32]);
                if (k == 8) check($sformatf("%s.op8.din", name), bus_log[k].din, 1);
            end
            check({name, ".t_a0"}, bus_log[0].cyc, t_acc + 1);
            check({name, ".t_trig"}, bus_log[8].cyc, t_acc + 17);
            check({name, ".t_poll"}, bus_log[9].cyc, t_acc + 19);
        end
    endtask

    typedef struct {
        bit           id;
        logic [255:0] data;
        logic [31:0]  emin;
        logic [31:0]  emax;
    } vec_t;

    vec_t         vecs [4];
    logic [255:0] tie_data [4];
    logic [31:0]  tie_min [4];
    logic [31:0]  tie_max [4];
    bit           exp_order [4];

    initial begin
        int t_acc;
        int stall_bad;
        int ready_bad;
        int nres;
        bit gq[$];
        bit p0, p1;
        int n0, n1;
        bit seen;

        vecs[0] = '{1'b0, pack8(5, -3, 12, 0, 7, -9, 4, 1), 32'hFFFF_FFF7, 32'd12};
        vecs[1] = '{1'b1, pack8(100, 200, 300, -400, 50, 0, 1, 2), 32'hFFFF_FE70, 32'd300};
        vecs[2] = '{1'b0, pack8(7, 7, 7, 7, 7, 7, 7, 7), 32'd7, 32'd7};
        vecs[3] = '{1'b1, pack8(32'h7FFF_FFFF, int'(32'h8000_0000), 0, 0, 0, 0, 0, 0),
                    32'h8000_0000, 32'h7FFF_FFFF};
        // Tie sequence in expected grant order: req0 job0, req1 job0, req0 job1, req1 job1.
        tie_data[0] = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        tie_data[1] = pack8(-1, -2, -3, -4, -5, -6, -7, -8);
        tie_data[2] = pack8(10, -10, 20, -20, 30, -30, 40, -40);
        tie_data[3] = pack8(1000, 0, 0, 0, 0, 0, 0, -1000);
        tie_min[0] = 32'd1;         tie_max[0] = 32'd8;
        tie_min[1] = 32'hFFFF_FFF8; tie_max[1] = 32'hFFFF_FFFF;
        tie_min[2] = 32'hFFFF_FFD8; tie_max[2] = 32'd40;
        tie_min[3] = 32'hFFFF_FC18; tie_max[3] = 32'd1000;
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk);

        // Both requesters valid from the first cycle after reset: req0 wins the first tie.
        p0 = 1'b0; p1 = 1'b0; n0 = 0; n1 = 0; nres = 0;
        req0_valid = 1'b1; req0_data = tie_data[0];
        req1_valid = 1'b1; req1_data = tie_data[1];
        #1;
        if (req0_ready) begin gq.push_back(1'b0); p0 = 1'b1; end
        if (req1_ready) begin gq.push_back(1'b1); p1 = 1'b1; end
        for (int i = 0; i < 600 && nres < 4; i++) begin
            @(negedge clk);
            if (p0) begin
                p0 = 1'b0; n0++;
                if (n0 < 2) req0_data = tie_data[2];
                else req0_valid = 1'b0;
            end
            if (p1) begin
                p1 = 1'b0; n1++;
                if (n1 < 2) req1_data = tie_data[3];
                else req1_valid = 1'b0;
            end
            if (res_ready) begin
                res_ready = 1'b0;
            end else if (res_valid) begin
                check($sformatf("tie.res%0d.id", nres), res_id, exp_order[nres]);
                check($sformatf("tie.res%0d.min", nres), res_min, tie_min[nres]);
                check($sformatf("tie.res%0d.max", nres), res_max, tie_max[nres]);
                nres++;
                res_ready = 1'b1;
            end
            #1;
            if (req0_ready) begin gq.push_back(1'b0); p0 = 1'b1; end
            if (req1_ready) begin gq.push_back(1'b1); p1 = 1'b1; end
        end
        @(negedge clk);
        res_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("tie.nres", nres, 4);
        check("tie.ngrants", gq.size(), 4);
        if (gq.size() == 4)
            for (int k = 0; k < 4; k++) check($sformatf("tie.grant%0d", k), gq[k], exp_order[k]);

        // Table-driven single jobs with full bus-sequence and latency checks.
        for (int v = 0; v < 4; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            bus_log.delete();
            start_job(nm, vecs[v].id, vecs[v].data, t_acc);
            wait_result(nm, vecs[v].id, vecs[v].emin, vecs[v].emax, 1'b0);
            check_bus_log(nm, vecs[v].data, compute_polls + 1, t_acc);
            handshake(nm);
        end

        // Result held for 20 cycles with req1 waiting: no grant until the handshake.
        start_job("stall", 1'b0, vecs[0].data, t_acc);
        req1_valid = 1'b1;
        req1_data  = vecs[1].data;
        wait_result("stall", 1'b0, vecs[0].emin, vecs[0].emax, 1'b0);
        stall_bad = 0;
        ready_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (res_valid !== 1'b1 || res_id !== 1'b0 || res_min !== vecs[0].emin ||
                res_max !== vecs[0].emax || res_err !== 1'b0) stall_bad++;
            if (req0_ready || req1_ready) ready_bad++;
        end
        check("stall.stable", stall_bad, 0);
        check("stall.no_ready", ready_bad, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("stall.valid_drop", res_valid, 0);
        check("stall.next_grant", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_result("stall2", 1'b1, vecs[1].emin, vecs[1].emax, 1'b0);
        handshake("stall2");

        // Reset while polling, then a fresh req1 job.
        start_job("rst", 1'b0, vecs[2].data, t_acc);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (acc_en && !acc_wr && acc_raddr == TRIG) seen = 1'b1;
        end
        check("rst.reached_poll", seen, 1);
        rst_ni = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        rst_ni = 1'b1;
        bus_log.delete();
        start_job("rst2", 1'b1, vecs[3].data, t_acc);
        wait_result("rst2", 1'b1, vecs[3].emin, vecs[3].emax, 1'b0);
        check_bus_log("rst2", vecs[3].data, compute_polls + 1, t_acc);
        handshake("rst2");

`ifdef MINMAX_SEQ_POLL_TIMEOUT_EN
        // Trigger never clears: exactly POLL_LIMIT polls, then an error result with zeros.
        never_clear = 1'b1;
        bus_log.delete();
        start_job("tmo", 1'b0, vecs[0].data, t_acc);
        wait_result("tmo", 1'b0, 32'd0, 32'd0, 1'b1);
        check("tmo.nops", bus_log.size(), 13);
        begin
            int npoll = 0;
            foreach (bus_log[k]) if (!bus_log[k].wr && bus_log[k].addr == TRIG) npoll++;
            check("tmo.npolls", npoll, 4);
        end
        handshake("tmo");
        never_clear = 1'b0;
`endif

        check("bus.violations", bus_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
